page_stream_qout: RTL and testbench
===================================

Name: page_stream_qout

Overview:
- Per-stream output queue for a page: buffers tokens emitted by the page FSM and drives them onto the inter-page stream network.
- Transmit-side counterpart of the page input queue. It uses the same token format (data plus end-of-stream flag) and the same valid/back-pressure handshake.
- Asserts back-pressure early, leaving RESERVE free slots. Tokens the producer already has in flight when stalled are therefore absorbed without loss.

Parameters:
WIDTH, 16, data bits per token (end-of-stream flag carried separately)
DEPTH, 8, queue entries; power of two, >= 2
RESERVE, 2, free slots held back for in-flight tokens; 0 <= RESERVE < DEPTH
AW, 3, pointer width = log2(DEPTH)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
qin_d  in  WIDTH  token data from page FSM
qin_e  in  1  end-of-stream flag of token
qin_v  in  1  producer token valid
qin_b  out  1  back-pressure to producer (1 = stall)
qout_d  out  WIDTH  token data to network
qout_e  out  1  end-of-stream flag to network
qout_v  out  1  token valid to network
qout_b  in  1  back-pressure from network (1 = stall)
closed  out  1  end-of-stream token has left the queue
ovf  out  1  sticky: push attempted with queue full, or after closed

Behaviour:
- Reset (reset=0, asynchronous): pointers=0, count=0, qout_v=0, qin_b=0, closed=0, ovf=0, state=OPEN. qout_d/qout_e=0.
- Storage: DEPTH x (WIDTH+1) register array; word = {d,e}.
- Push:
  - Occurs when qin_v=1, count<DEPTH and state=OPEN. Write at wptr; wptr wraps DEPTH-1 -> 0.
  - The producer is not required to honour qin_b instantly: up to RESERVE tokens after qin_b rises are accepted.
- Pop:
  - Occurs when qout_v=1 and qout_b=0. rptr increments with wrap.
  - qout_d/qout_e/qout_v are combinational from the head entry, so first-word latency is 1 cycle (token pushed in cycle N is visible in cycle N+1).
- Simultaneous push and pop: count unchanged. Both are legal at full (pop frees the slot in the same edge) and at empty (push only; the token appears next cycle, with no bypass).
- qin_b = (count >= DEPTH-RESERVE) or state != OPEN. Registered from next-state count, so there is no combinational path from qout_b to qin_b.
- Full (count=DEPTH) with qin_v=1 and no pop: token dropped, ovf set.
- State machine:
  - OPEN -> DRAIN when a token with qin_e=1 is pushed. Further pushes are rejected; qin_b=1.
  - DRAIN -> CLOSED when the eos token is popped; closed=1.
  - CLOSED holds until reset. qin_v=1 in DRAIN or CLOSED sets ovf and the token is dropped.
- qout_v=0 when count=0. closed never asserts while tokens remain queued.

Optional Feature:
PAGE_STREAM_QOUT_OCC_EN
- With the macro: adds output port occ [AW:0] = current count, registered, reset 0. This is for page-level flow-control profiling.
- Without the macro: port absent; no extra logic.

Decomposition:
- Shared package holds:
  - stream state encoding (ST_OPEN=2'd0, ST_DRAIN=2'd1, ST_CLOSED=2'd2)
  - token-word layout constants (eos bit position 0, data at [WIDTH:1])
  - default WIDTH/DEPTH/RESERVE
- One sub-module: page_stream_qout_ram, a DEPTH x (WIDTH+1) register-file with one write port and one asynchronous read port. Pointer, count and FSM logic stay in the top.

Test Plan:
1. Basic flow: push 0x0001..0x0005 (e=0) with qout_b=0 -> identical values out in order, each one cycle after push; count returns to 0; qin_b stays 0.
2. Reserve:
   - Setup: DEPTH=8, RESERVE=2, hold qout_b=1, push continuously.
   - Expected: qin_b=1 after the 6th token is stored; 7th and 8th accepted; 9th dropped; ovf=1.
3. Full-boundary simultaneous push/pop: at count=8, qin_v=1 and qout_b=0 -> count stays 8; no ovf; order preserved across wptr/rptr wrap.
4. End of stream:
   - Stimulus: push 0x00AA, then 0x00BB with e=1, then 0x00CC.
   - Expected: 0x00CC rejected and ovf=1; qin_b=1 from the cycle after eos is pushed; closed=1 in the cycle after 0x00BB pops with qout_e=1.
5. Async reset mid-stream: assert reset low between clock edges with 3 tokens queued -> qout_v, qin_b, closed, ovf drop to 0 immediately; after release, a new push of 0x1234 emerges correctly.
6. With PAGE_STREAM_QOUT_OCC_EN: push 4, pop 1 -> occ reads 4 then 3, tracking count each cycle.

Source files
------------

// File: rtl/page_stream_qout_pkg.sv
// page_stream_qout shared types and constants.
// Token word layout, stream states and default sizing.
package page_stream_qout_pkg;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_CLOSED = 2'd2
  } st_e;

  localparam int EOS_BIT     = 0;
  localparam int DATA_LSB    = 1;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_RESERVE = 2;

endpackage

// File: rtl/page_stream_qout_ram.sv
// page_stream_qout token store: DEPTH x (WIDTH+1) register file,
// one synchronous write port, one asynchronous read port.
module page_stream_qout_ram
  import page_stream_qout_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [WIDTH:0]  i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [WIDTH:0]  o_rdata
);

  logic [WIDTH:0] r_mem [DEPTH];

  // write the pushed token word
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/page_stream_qout.sv
// page_stream_qout: per-stream output queue with early back-pressure.
// Optional macro PAGE_STREAM_QOUT_OCC_EN adds the occ output.
module page_stream_qout
  import page_stream_qout_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int RESERVE = DEF_RESERVE,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] qin_d,
  input  logic             qin_e,
  input  logic             qin_v,
  output logic             qin_b,
  output logic [WIDTH-1:0] qout_d,
  output logic             qout_e,
  output logic             qout_v,
  input  logic             qout_b,
  output logic             closed,
  output logic             ovf
`ifdef PAGE_STREAM_QOUT_OCC_EN
  ,
  output logic [AW:0]      occ
`endif
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_HI   = (AW+1)'(DEPTH - RESERVE);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic [AW:0]   w_cnt_nxt;
  st_e           r_state;
  st_e           w_state_nxt;
  logic          r_qinb;
  logic          r_ovf;
  logic [WIDTH:0] w_head;
  logic [WIDTH:0] w_wword;
  logic          w_push;
  logic          w_pop;
  logic          w_open;
  logic          w_nempty;

  assign w_nempty = (r_cnt != '0);
  assign w_pop    = w_nempty & ~qout_b;
  assign w_open   = (r_state == ST_OPEN);
  // at full, a same-cycle pop frees the slot being written
  assign w_push   = qin_v & w_open & ((r_cnt != L_FULL) | w_pop);
  assign w_wword  = {qin_d, qin_e};

  page_stream_qout_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wword),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  assign qout_v = w_nempty;
  assign qout_d = w_nempty ? w_head[WIDTH:DATA_LSB] : '0;
  assign qout_e = w_nempty & w_head[EOS_BIT];
  assign qin_b  = r_qinb;
  assign ovf    = r_ovf;
  assign closed = (r_state == ST_CLOSED);

`ifdef PAGE_STREAM_QOUT_OCC_EN
  assign occ = r_cnt;
`endif

  // next stream state and next occupancy
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_OPEN:   if (w_push & qin_e) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_pop & qout_e) w_state_nxt = ST_CLOSED;
      ST_CLOSED: w_state_nxt = ST_CLOSED;
      default:   w_state_nxt = r_state;
    endcase
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // pointers, count, state, stall and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_state <= ST_OPEN;
      r_qinb  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_qinb  <= (w_cnt_nxt >= L_HI) | (w_state_nxt != ST_OPEN);
      if (qin_v & ~w_push) r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_page_stream_qout.sv
// page_stream_qout bench: directed stimulus, queue scoreboard,
// negedge monitor popping expected tokens.
module tb_page_stream_qout;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] qin_d;
  logic        qin_e;
  logic        qin_v;
  logic        qin_b;
  logic [15:0] qout_d;
  logic        qout_e;
  logic        qout_v;
  logic        qout_b;
  logic        closed;
  logic        ovf;
`ifdef PAGE_STREAM_QOUT_OCC_EN
  logic [3:0]  occ;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [16:0] sb[$];

  page_stream_qout dut (
    .clock  (clock),
    .reset  (reset),
    .qin_d  (qin_d),
    .qin_e  (qin_e),
    .qin_v  (qin_v),
    .qin_b  (qin_b),
    .qout_d (qout_d),
    .qout_e (qout_e),
    .qout_v (qout_v),
    .qout_b (qout_b),
    .closed (closed),
    .ovf    (ovf)
`ifdef PAGE_STREAM_QOUT_OCC_EN
    ,
    .occ    (occ)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // drive one token; queue it as expected only if it should be accepted
  task automatic drive(input logic [15:0] d, input logic e,
                       input bit acc);
    qin_v = 1'b1;
    qin_d = d;
    qin_e = e;
    if (acc) sb.push_back({d, e});
  endtask

  // monitor: every token leaving the queue must match the scoreboard head
  always @(negedge clock) begin
    if (reset && qout_v && !qout_b) begin
      logic [16:0] exp_w;
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL mon_unexpected: got %0h expected none",
                 {qout_d, qout_e});
      end else begin
        exp_w = sb.pop_front();
        if ({qout_d, qout_e} !== exp_w) begin
          n_miss++;
          $display("FAIL mon_token: got %0h expected %0h",
                   {qout_d, qout_e}, exp_w);
        end
      end
    end
  end

  initial begin
    reset  = 1'b0;
    qin_d  = '0;
    qin_e  = 1'b0;
    qin_v  = 1'b0;
    qout_b = 1'b0;
    #12;
    chk("rst_qout_v", qout_v, 0);
    chk("rst_qin_b", qin_b, 0);
    chk("rst_closed", closed, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_qout_d", {qout_d, qout_e}, 0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // 1: basic flow, one-cycle latency, pops every cycle
    qout_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(16'(i), 1'b0, 1'b1);
      step();
      chk("t1_v", qout_v, 1);
      chk("t1_d", qout_d, i);
      chk("t1_qin_b", qin_b, 0);
    end
    qin_v = 1'b0;
    step();
    chk("t1_empty", qout_v, 0);

    // 3: fill to 8 across pointer wrap, then push+pop at full
    qout_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(16'h30 + 16'(i), 1'b0, 1'b1);
      step();
    end
    chk("t3_full_qin_b", qin_b, 1);
    chk("t3_full_ovf", ovf, 0);
    drive(16'h38, 1'b0, 1'b1);
    qout_b = 1'b0;
    step();
    chk("t3_pp_ovf", ovf, 0);
    chk("t3_pp_qin_b", qin_b, 1);
    chk("t3_pp_head", qout_d, 16'h31);
    qin_v = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("t3_drained", qout_v, 0);
    chk("t3_sb", sb.size(), 0);

    // 2: reserve threshold and overflow at full
    qout_b = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      drive(16'h40 + 16'(i), 1'b0, i <= 8);
      step();
      chk("t2_qin_b", qin_b, i >= 6);
      chk("t2_ovf", ovf, i >= 9);
    end
    qin_v  = 1'b0;
    qout_b = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("t2_drained", qout_v, 0);
    chk("t2_sb", sb.size(), 0);

    // 4: end of stream
    reset = 1'b0;
    #2;
    reset = 1'b1;
    chk("t4_ovf_clr", ovf, 0);
    qout_b = 1'b1;
    drive(16'h00AA, 1'b0, 1'b1);
    step();
    chk("t4_qin_b0", qin_b, 0);
    drive(16'h00BB, 1'b1, 1'b1);
    step();
    chk("t4_qin_b1", qin_b, 1);
    chk("t4_ovf0", ovf, 0);
    drive(16'h00CC, 1'b0, 1'b0);
    step();
    chk("t4_ovf1", ovf, 1);
    chk("t4_closed0", closed, 0);
    qin_v  = 1'b0;
    qout_b = 1'b0;
    step();
    chk("t4_closed_mid", closed, 0);
    chk("t4_head_e", qout_e, 1);
    chk("t4_head_d", qout_d, 16'h00BB);
    step();
    chk("t4_closed1", closed, 1);
    chk("t4_empty", qout_v, 0);

    // 5: async reset with tokens queued
    reset = 1'b0;
    #2;
    reset = 1'b1;
    sb.delete();
    qout_b = 1'b1;
    drive(16'h51, 1'b0, 1'b0);
    step();
    drive(16'h52, 1'b0, 1'b0);
    step();
    drive(16'h53, 1'b1, 1'b0);
    step();
    drive(16'h54, 1'b0, 1'b0);
    step();
    qin_v = 1'b0;
    chk("t5_pre_v", qout_v, 1);
    chk("t5_pre_b", qin_b, 1);
    chk("t5_pre_ovf", ovf, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_v", qout_v, 0);
    chk("t5_qin_b", qin_b, 0);
    chk("t5_closed", closed, 0);
    chk("t5_ovf", ovf, 0);
    #1;
    reset  = 1'b1;
    qout_b = 1'b0;
    step();
    drive(16'h1234, 1'b0, 1'b1);
    step();
    chk("t5_new_v", qout_v, 1);
    chk("t5_new_d", qout_d, 16'h1234);
    qin_v = 1'b0;
    step();
    chk("t5_new_empty", qout_v, 0);

`ifdef PAGE_STREAM_QOUT_OCC_EN
    // 6: occupancy tracking
    qout_b = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(16'h60 + 16'(i), 1'b0, 1'b1);
      step();
      chk("t6_occ_up", occ, i);
    end
    qin_v  = 1'b0;
    qout_b = 1'b0;
    step();
    chk("t6_occ_pop", occ, 3);
    for (int i = 0; i < 3; i++) step();
    chk("t6_occ_end", occ, 0);
`endif

    chk("sb_final", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
